// File: rtl/rag_retrieval_pkg.sv
// Shared types for the retrieval path: score/doc-id types, ranked-list entry
// and the top-K selector state encoding.
package rag_retrieval_pkg;

    localparam int DOC_ID_W_DEF = 32;
    localparam int SCORE_W_DEF  = 32;

    typedef logic signed [SCORE_W_DEF-1:0] score_t;
    typedef logic        [DOC_ID_W_DEF-1:0] doc_id_t;

    typedef struct packed {
        doc_id_t doc_id;
        score_t  score;
    } topk_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT,
        DONE
    } topk_state_t;

endpackage

// File: rtl/topk_insert_slot.sv
// One position of the sorted top-K list: decides whether this slot keeps its
// entry, takes the new candidate, or takes the entry shifting down from above.
module topk_insert_slot #(
    parameter int DOC_ID_W = 32,
    parameter int SCORE_W  = 32
) (
    input  logic                i_own_valid,
    input  logic [DOC_ID_W-1:0] i_own_doc,
    input  logic [SCORE_W-1:0]  i_own_score,
    input  logic [DOC_ID_W-1:0] i_up_doc,
    input  logic [SCORE_W-1:0]  i_up_score,
    input  logic                i_up_gt,
    input  logic [DOC_ID_W-1:0] i_new_doc,
    input  logic [SCORE_W-1:0]  i_new_score,
    output logic [DOC_ID_W-1:0] o_next_doc,
    output logic [SCORE_W-1:0]  o_next_score,
    output logic                o_gt
);

    // An empty slot always loses to the candidate; a tie keeps the older entry.
    assign o_gt = !i_own_valid || ($signed(i_new_score) > $signed(i_own_score));

    always_comb begin
        o_next_doc   = i_own_doc;
        o_next_score = i_own_score;
        if (o_gt) begin
            if (i_up_gt) begin
                o_next_doc   = i_up_doc;
                o_next_score = i_up_score;
            end else begin
                o_next_doc   = i_new_doc;
                o_next_score = i_new_score;
            end
        end
    end

endmodule

// File: rtl/topk_selector.sv
// Streaming top-K ranker: collects (doc_id, score) candidates into a sorted
// list with single-cycle insertion, then emits the ranked list under handshake.
module topk_selector
    import rag_retrieval_pkg::*;
#(
    parameter  int TOP_K    = 8,
    parameter  int DOC_ID_W = 32,
    parameter  int SCORE_W  = 32,
    localparam int RANK_W   = (TOP_K > 1) ? $clog2(TOP_K) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DOC_ID_W-1:0] in_doc_id,
    input  logic [SCORE_W-1:0]  in_score,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RANK_W-1:0]   out_rank,
    output logic [DOC_ID_W-1:0] out_doc_id,
    output logic [SCORE_W-1:0]  out_score,
    output logic                out_last,
    output logic                done
);

    localparam int CNT_W = $clog2(TOP_K + 1);

    topk_state_t         r_state;
    topk_state_t         w_state_next;
    logic [CNT_W-1:0]    r_count;
    logic [RANK_W-1:0]   r_emit_idx;
    logic                w_accept;
    logic                w_emit_last;

    logic [DOC_ID_W-1:0] w_doc      [TOP_K];
    logic [SCORE_W-1:0]  w_score    [TOP_K];
    logic [DOC_ID_W-1:0] w_doc_next [TOP_K];
    logic [SCORE_W-1:0]  w_score_nxt[TOP_K];
    logic                w_gt       [TOP_K];
    logic                w_valid    [TOP_K];

    assign w_accept    = (r_state == COLLECT) && in_valid;
    assign w_emit_last = ((CNT_W'(r_emit_idx) + CNT_W'(1)) == r_count);

    genvar gi;
    generate
        for (gi = 0; gi < TOP_K; gi++) begin : g_slot
            logic [DOC_ID_W-1:0] r_doc;
            logic [SCORE_W-1:0]  r_score;
            logic [DOC_ID_W-1:0] w_up_doc;
            logic [SCORE_W-1:0]  w_up_score;
            logic                w_up_gt;

            if (gi == 0) begin : g_head
                assign w_up_doc   = '0;
                assign w_up_score = '0;
                assign w_up_gt    = 1'b0;
            end else begin : g_body
                assign w_up_doc   = w_doc[gi-1];
                assign w_up_score = w_score[gi-1];
                assign w_up_gt    = w_gt[gi-1];
            end

            assign w_valid[gi] = (r_count > CNT_W'(gi));
            assign w_doc[gi]   = r_doc;
            assign w_score[gi] = r_score;

            topk_insert_slot #(
                .DOC_ID_W (DOC_ID_W),
                .SCORE_W  (SCORE_W)
            ) u_slot (
                .i_own_valid  (w_valid[gi]),
                .i_own_doc    (r_doc),
                .i_own_score  (r_score),
                .i_up_doc     (w_up_doc),
                .i_up_score   (w_up_score),
                .i_up_gt      (w_up_gt),
                .i_new_doc    (in_doc_id),
                .i_new_score  (in_score),
                .o_next_doc   (w_doc_next[gi]),
                .o_next_score (w_score_nxt[gi]),
                .o_gt         (w_gt[gi])
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_doc   <= '0;
                    r_score <= '0;
                end else if (w_accept) begin
                    r_doc   <= w_doc_next[gi];
                    r_score <= w_score_nxt[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != IDLE);
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_rank     = '0;
        out_doc_id   = '0;
        out_score    = '0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = COLLECT;
            end
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && in_last) w_state_next = EMIT;
            end
            EMIT: begin
                out_valid  = 1'b1;
                out_last   = w_emit_last;
                out_rank   = r_emit_idx;
                out_doc_id = w_doc[r_emit_idx];
                out_score  = w_score[r_emit_idx];
                if (out_ready && w_emit_last) w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_emit_idx <= '0;
        end else begin
            r_state <= w_state_next;
            // Count saturates at TOP_K; a full list just displaces its tail.
            if (r_state == IDLE && start) begin
                r_count <= '0;
            end else if (w_accept && r_count != CNT_W'(TOP_K)) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (r_state == COLLECT) begin
                r_emit_idx <= '0;
            end else if (r_state == EMIT && out_ready) begin
                r_emit_idx <= r_emit_idx + 1'b1;
            end
        end
    end

endmodule

// File: doc/topk_selector.md
Name: topk_selector

Overview:
- Streaming top-K ranker that sits directly downstream of the similarity stage in the retrieval path.
- Consumes one (doc_id, score) pair per cycle and maintains a descending-sorted list of the K best scores.
- After the final candidate of a query is accepted, emits the ranked list to the context-assembly stage.

Parameters:
- TOP_K, 8: number of results retained; legal range 1..64.
- DOC_ID_W, 32: width of the document identifier.
- SCORE_W, 32: width of the similarity score. Scores are signed two's-complement; larger is better.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begins a new query; honoured only in IDLE
- busy  output  1  high in any state other than IDLE
- in_valid  input  1  candidate valid
- in_ready  output  1  block accepts a candidate
- in_doc_id  input  DOC_ID_W  candidate document id
- in_score  input  SCORE_W  candidate similarity score
- in_last  input  1  marks the final candidate of the query
- out_valid  output  1  ranked result valid
- out_ready  input  1  downstream accepts the result
- out_rank  output  $clog2(TOP_K) (min 1)  0 = best
- out_doc_id  output  DOC_ID_W  result document id
- out_score  output  SCORE_W  result score
- out_last  output  1  marks the final result of the query
- done  output  1  one-cycle pulse after the final result transfers

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Reset takes effect at any time, including mid-query.
- Reset values: state=IDLE; every output 0; list count=0; list entries 0.
- States:
  - IDLE: in_ready=0, out_valid=0. start -> clear count, go to COLLECT.
  - COLLECT: in_ready=1. Each in_valid&in_ready cycle inserts the candidate. If in_last is set on that transfer, go to EMIT on the next cycle. Insertion completes in the same cycle it is accepted, so the updated list is visible next cycle.
  - EMIT: in_ready=0. Presents list entry emit_idx, starting at 0, with out_valid=1, out_rank=emit_idx, out_last=(emit_idx==count-1). Outputs hold stable while out_valid&!out_ready. On a transfer, emit_idx++. A transfer with out_last -> DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Insertion rule (single-cycle parallel compare-and-shift):
  - A new score is placed after every entry with score >= new, so ties keep the earlier arrival.
  - Entries below the new one shift down by one position.
- Count and drop rule:
  - count<TOP_K: count increments, nothing is dropped.
  - count==TOP_K: the last entry is discarded. If the new score <= the current last score, the candidate is dropped and the list is unchanged.
- Comparisons are signed over the full SCORE_W; there is no saturation or rounding.
- Candidate count per query is unbounded. count saturates at TOP_K.
- Every query contains at least one candidate, because in_last rides on a candidate. EMIT therefore always emits count (>=1) results.
- start outside IDLE is ignored. in_valid outside COLLECT is ignored (not accepted).
- Latency:
  - Last candidate accepted at cycle t -> first out_valid at t+1.
  - With out_ready held high, results go out one per cycle: TOP_K results leave at t+1..t+TOP_K, and done pulses at t+TOP_K+1.

Decomposition:
- Shared package rag_retrieval_pkg holds:
  - score_t and doc_id_t typedefs;
  - a topk_entry_t struct {doc_id, score};
  - the topk_state_t enum (IDLE, COLLECT, EMIT, DONE).
- Sub-module topk_insert_slot, one instance per list position:
  - inputs: own entry, upper neighbour's entry, the new candidate, and the upper neighbour's "new > entry" compare result;
  - computes its next entry as keep, take-new, or take-upper;
  - outputs its own compare bit to the next slot down.
- The top level holds the FSM, count, emit_idx and output muxing.

Test Plan (TOP_K=4):
- Basic ranking: scores 10,50,30,20,40 (ids 1..5, last on id5), out_ready=1 -> ids 2,5,3,4 with scores 50,40,30,20; ranks 0..3; out_last on rank 3; done one cycle later.
- Fewer than K: scores 7 then -3 (last) -> two results (7, -3); out_last on rank 1. Confirms the signed compare.
- Ties and drop: scores 5,5,5,5,5 (ids 1..5) -> ids 1,2,3,4; id5 is dropped.
- Backpressure: out_ready toggled 1,0,0,1 -> outputs stable during stalls; each result transfers exactly once; done still follows the last result.
- Reset mid-EMIT: assert rst_n low during rank 1 -> next cycle out_valid=0, busy=0. A new start plus a single candidate 99 (last) emits only 99.
- Protocol guards: start during COLLECT and in_valid during IDLE/EMIT -> no effect on the list or the state.
